// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide front-end sequencer:
// FSM state encoding, step-counter width and default capture points.
package multdiv_sequencer_pkg;

  localparam int COUNT_W       = 5;
  localparam int MULT_LAST_DEF = 15;
  localparam int DIV_LAST_DEF  = 31;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_MULT = 2'd1,
    RUN_DIV  = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage : multdiv_sequencer_pkg

// File: rtl/multdiv_step_counter.sv
// Step counter shared by the iterative multiply/divide units: synchronous
// clear has priority over enable; holds its value when neither is asserted.
module multdiv_step_counter
  import multdiv_sequencer_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : multdiv_step_counter

// File: rtl/multdiv_sequencer.sv
// Front-end controller for the shared multiply/divide datapath: latches
// operands on a start pulse, steps the units and captures the final result.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int MULT_LAST = MULT_LAST_DEF,
  parameter int DIV_LAST  = DIV_LAST_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic               ctrl_DIV,
  input  logic [31:0]        data_operandA,
  input  logic [31:0]        data_operandB,
  output logic [31:0]        unit_operandA,
  output logic [31:0]        unit_operandB,
  output logic [COUNT_W-1:0] count,
  output logic               unitReset,
  input  logic [31:0]        mult_result,
  input  logic               mult_overflow,
  input  logic [31:0]        div_result,
  input  logic               div_exception,
  output logic [31:0]        data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);

  // Capture points must fit the 5-bit counter; the counter never wraps in a run.
  localparam logic [COUNT_W-1:0] MULT_LAST_C = COUNT_W'(MULT_LAST);
  localparam logic [COUNT_W-1:0] DIV_LAST_C  = COUNT_W'(DIV_LAST);

  state_e      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic        unit_reset_q, unit_reset_d;
  logic        cnt_clear;
  logic        cnt_enable;
  logic        start;

  assign start = ctrl_MULT | ctrl_DIV;

  multdiv_step_counter u_step_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (count)
  );

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    exc_d        = exc_q;
    rdy_d        = 1'b0;
    busy_d       = busy_q;
    unit_reset_d = 1'b0;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;

    if (start) begin
      // A start in any state restarts; it also overrides a same-edge capture.
      state_d      = ctrl_MULT ? RUN_MULT : RUN_DIV;
      op_a_d       = data_operandA;
      op_b_d       = data_operandB;
      busy_d       = 1'b1;
      unit_reset_d = 1'b1;
      cnt_clear    = 1'b1;
    end else begin
      unique case (state_q)
        RUN_MULT: begin
          if (count == MULT_LAST_C) begin
            result_d = mult_result;
            exc_d    = mult_overflow;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
            state_d  = DONE;
          end else begin
            cnt_enable = 1'b1;
          end
        end
        RUN_DIV: begin
          if (count == DIV_LAST_C) begin
            // A zero divisor is reported here regardless of the unit's outputs.
            if (op_b_q == '0) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else begin
              result_d = div_result;
              exc_d    = div_exception;
            end
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_enable = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      unit_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      unit_reset_q <= unit_reset_d;
    end
  end

  assign unit_operandA  = op_a_q;
  assign unit_operandB  = op_b_q;
  assign unitReset      = unit_reset_q | reset;
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule : multdiv_sequencer

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: table of complete operations plus
// hand-written abort, start/capture collision and mid-run reset sequences.
module tb_multdiv_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] unit_operandA;
  logic [31:0] unit_operandB;
  logic [4:0]  count;
  logic        unitReset;
  logic [31:0] mult_result;
  logic        mult_overflow;
  logic [31:0] div_result;
  logic        div_exception;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .unit_operandA  (unit_operandA),
    .unit_operandB  (unit_operandB),
    .count          (count),
    .unitReset      (unitReset),
    .mult_result    (mult_result),
    .mult_overflow  (mult_overflow),
    .div_result     (div_result),
    .div_exception  (div_exception),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Unit models: valid outputs only on the final step, junk otherwise, so a
  // capture on the wrong count shows up as a wrong result.
  logic signed [63:0] prod;
  assign prod          = $signed(unit_operandA) * $signed(unit_operandB);
  assign mult_result   = (count == 5'd15) ? prod[31:0] : 32'hDEAD_BEEF;
  assign mult_overflow = (count == 5'd15) ? (prod != {{32{prod[31]}}, prod[31:0]}) : 1'b1;
  assign div_result    = (count != 5'd31) ? 32'hCAFE_F00D :
                         (unit_operandB == 32'd0) ? 32'h0000_1234 :
                         unit_operandA / unit_operandB;
  assign div_exception = (count != 5'd31);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Values observed by watch(); index 0 is the first falling edge after the start edge.
  int          first_rdy;
  int          n_rdy;
  logic        ur0, ur1, busy0, busy_at, exc_at;
  logic [31:0] res0, res_at, opa5, opb5;
  logic [4:0]  cnt_at, cnt_end;

  task automatic watch(input int n);
    first_rdy = -1;
    n_rdy     = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i == 0) begin
        ur0   = unitReset;
        busy0 = busy;
        res0  = data_result;
      end
      if (i == 1) ur1 = unitReset;
      if (i == 5) begin
        opa5 = unit_operandA;
        opb5 = unit_operandB;
      end
      if (data_resultRDY) begin
        n_rdy++;
        if (first_rdy < 0) begin
          first_rdy = i;
          res_at    = data_result;
          exc_at    = data_exception;
          busy_at   = busy;
          cnt_at    = count;
        end
      end
      cnt_end = count;
    end
  endtask

  // Called at a falling edge; the next rising edge is the start edge.
  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'h5A5A_5A5A;
    data_operandB = 32'hA5A5_A5A5;
  endtask

  typedef struct {
    logic        do_mult;
    logic        do_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_exc;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] prev_res;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 16};
    vecs[1] = '{1'b0, 1'b1, 32'd100,        32'd7,         32'd14,        1'b0, 32};
    vecs[2] = '{1'b0, 1'b1, 32'd5,          32'd0,         32'd0,         1'b1, 32};
    vecs[3] = '{1'b1, 1'b1, 32'd6,          32'd9,         32'd54,        1'b0, 16};
    vecs[4] = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'd0,         1'b1, 16};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0, 32};

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #3;
    check("rst_unitReset", 32'(unitReset), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(data_resultRDY), 32'd0);
    check("rst_result", data_result, 32'd0);
    check("rst_opA", unit_operandA, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rel_unitReset", 32'(unitReset), 32'd0);
    @(negedge clock);

    prev_res = 32'd0;
    for (int i = 0; i < 6; i++) begin
      start(vecs[i].do_mult, vecs[i].do_div, vecs[i].a, vecs[i].b);
      watch(36);
      check($sformatf("v%0d_latency", i), 32'(first_rdy), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_pulses", i), 32'(n_rdy), 32'd1);
      check($sformatf("v%0d_result", i), res_at, vecs[i].exp_res);
      check($sformatf("v%0d_exc", i), 32'(exc_at), 32'(vecs[i].exp_exc));
      check($sformatf("v%0d_busy_rdy", i), 32'(busy_at), 32'd0);
      check($sformatf("v%0d_busy_start", i), 32'(busy0), 32'd1);
      check($sformatf("v%0d_ur0", i), 32'(ur0), 32'd1);
      check($sformatf("v%0d_ur1", i), 32'(ur1), 32'd0);
      check($sformatf("v%0d_held_res", i), res0, prev_res);
      check($sformatf("v%0d_opA", i), opa5, vecs[i].a);
      check($sformatf("v%0d_opB", i), opb5, vecs[i].b);
      check($sformatf("v%0d_cnt_rdy", i), 32'(cnt_at), 32'(vecs[i].exp_lat - 1));
      check($sformatf("v%0d_cnt_idle", i), 32'(cnt_end), 32'(vecs[i].exp_lat - 1));
      prev_res = vecs[i].exp_res;
    end

    // Abort: multiply restarted as a divide on the sixth edge after its start.
    start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    watch(6);
    check("abort_first_ur0", 32'(ur0), 32'd1);
    check("abort_first_pulses", 32'(n_rdy), 32'd0);
    start(1'b0, 1'b1, 32'd100, 32'd7);
    watch(40);
    check("abort_ur0", 32'(ur0), 32'd1);
    check("abort_ur1", 32'(ur1), 32'd0);
    check("abort_latency", 32'(first_rdy), 32'd32);
    check("abort_pulses", 32'(n_rdy), 32'd1);
    check("abort_result", res_at, 32'd14);
    prev_res = 32'd14;

    // Start on the multiply's capture edge: capture is discarded.
    start(1'b1, 1'b0, 32'd6, 32'd9);
    watch(16);
    check("coll_pre_pulses", 32'(n_rdy), 32'd0);
    start(1'b0, 1'b1, 32'd100, 32'd7);
    watch(36);
    check("coll_held_res", res0, prev_res);
    check("coll_latency", 32'(first_rdy), 32'd32);
    check("coll_pulses", 32'(n_rdy), 32'd1);
    check("coll_result", res_at, 32'd14);

    // Asynchronous reset in the middle of a multiply.
    start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    watch(9);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_result", data_result, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_opA", unit_operandA, 32'd0);
    check("mid_rst_unitReset", 32'(unitReset), 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    watch(30);
    check("mid_rst_no_pulse", 32'(n_rdy), 32'd0);
    start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    watch(20);
    check("post_rst_latency", 32'(first_rdy), 32'd16);
    check("post_rst_result", res_at, 32'hFFFF_FFEB);
    check("post_rst_pulses", 32'(n_rdy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multdiv_sequencer

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Front-end controller for the shared multiply/divide datapath.
- Accepts single-cycle start pulses for multiply or divide and latches the operands. Drives the 5-bit step counter and unit reset that the iterative units consume.
- Captures the selected unit's result and exception, then raises a one-cycle ready pulse to the pipeline's stall logic.

Parameters:
- MULT_LAST, 15, counter value on which the multiplier's result is final and is captured.
- DIV_LAST, 31, counter value on which the divider's result is final and is captured.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ctrl_MULT  input  1  start-multiply pulse.
- ctrl_DIV  input  1  start-divide pulse.
- data_operandA  input  32  multiplicand / dividend.
- data_operandB  input  32  multiplier / divisor.
- unit_operandA  output  32  latched A, held stable for the whole operation.
- unit_operandB  output  32  latched B, held stable for the whole operation.
- count  output  5  step count driven to both units.
- unitReset  output  1  clears the unit datapath registers.
- mult_result  input  32  multiplier result.
- mult_overflow  input  1  multiplier overflow flag.
- div_result  input  32  divider quotient.
- div_exception  input  1  divider exception flag.
- data_result  output  32  captured result.
- data_exception  output  1  captured exception.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (asynchronous): the following take their reset values.
  - State = IDLE.
  - count = 0.
  - unitReset = 1 while reset is asserted, otherwise 0.
  - unit_operandA/B = 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
- States: IDLE, RUN_MULT, RUN_DIV, DONE.
- Start, sampled on a rising edge in any state:
  - ctrl_MULT=1 goes to RUN_MULT; ctrl_DIV=1 (with ctrl_MULT=0) goes to RUN_DIV.
  - On that edge: operands latched, count := 0, busy := 1, data_resultRDY := 0.
  - data_result and data_exception keep their previous values until the new capture.
- Both ctrl_MULT and ctrl_DIV high on the same edge: multiply wins; the divide request is dropped.
- Start while RUN_* or DONE: the current operation is aborted and the new one starts.
  - No ready pulse is produced for the aborted operation.
  - unitReset pulses high for the one cycle after the start edge so the units see clean state together with count=0.
- RUN_MULT:
  - count increments by 1 per edge.
  - On the edge where count==MULT_LAST: data_result := mult_result, data_exception := mult_overflow, state := DONE.
- RUN_DIV:
  - Same as RUN_MULT, but capture occurs when count==DIV_LAST, taking div_result and div_exception.
  - Divisor of zero latched at start: divider still runs full length. The sequencer forces data_result := 0 and data_exception := 1 at capture, whatever the unit outputs.
- DONE:
  - data_resultRDY=1 and busy=0 for exactly one cycle, then IDLE.
  - count holds at its last value through DONE and IDLE.
- Latency, start edge to data_resultRDY high: MULT_LAST+1 cycles for multiply (16), DIV_LAST+1 cycles for divide (32).
- count wrap: count never wraps during a run. DIV_LAST ≤ 31 and MULT_LAST ≤ 31 are required; values above 31 are illegal.
- Start pulse arriving on the same edge as a capture: the start wins, capture is discarded, no ready pulse.
- Reset mid-operation: immediate return to IDLE, no ready pulse, outputs to reset values.

Decomposition:
- Shared package holds:
  - state encoding (2-bit IDLE=0, RUN_MULT=1, RUN_DIV=2, DONE=3);
  - COUNT_W=5;
  - default MULT_LAST and DIV_LAST constants.
- One natural sub-module: multdiv_step_counter (5-bit counter with synchronous clear, enable, async reset).

Test Plan:
- Multiply: A=7, B=-3 via ctrl_MULT pulse, unit model returns -21 at count 15 → data_resultRDY high exactly 16 cycles after the start edge; data_result=0xFFFFFFEB, data_exception=0, busy low in that cycle.
- Divide: A=100, B=7 via ctrl_DIV → data_resultRDY after 32 cycles, data_result=14.
- Divide-by-zero: A=5, B=0 → data_resultRDY after 32 cycles, data_result=0, data_exception=1.
- Abort: ctrl_MULT, then ctrl_DIV at cycle 6 → no ready pulse at cycle 16; a single pulse 32 cycles after the second start; unitReset high for one cycle after each start.
- Simultaneous ctrl_MULT and ctrl_DIV high → multiply runs; ready pulse after 16 cycles.
- Reset asserted asynchronously at cycle 9 of a multiply → outputs zero immediately; no ready pulse ever; next ctrl_MULT completes normally.
